// File: rtl/riscv_biu_arbiter.sv
// Arbitrates the I/D front ends onto one BIU: grant 1 cycle after request, outstanding-drain before switch.
// Backpressure: biu_stb stalls at MAX_OUT outstanding, at quantum expiry, and for the whole DRAIN phase.
module riscv_biu_arbiter #(
   parameter int XLEN    = 64,
   parameter int PLEN    = 64,
   parameter int MAX_OUT = 2,
   parameter int QUANTUM = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_stb,
   input  logic            d_stb,
   output logic            i_stb_ack,
   output logic            d_stb_ack,
   input  logic [PLEN-1:0] i_adri,
   input  logic [PLEN-1:0] d_adri,
   input  logic [2:0]      i_size,
   input  logic [2:0]      d_size,
   input  logic [2:0]      i_type,
   input  logic [2:0]      d_type,
   input  logic            i_lock,
   input  logic            d_lock,
   input  logic            i_we,
   input  logic            d_we,
   input  logic [XLEN-1:0] i_di,
   input  logic [XLEN-1:0] d_di,
   input  logic            i_is_cacheable,
   input  logic            d_is_cacheable,
   input  logic            i_is_instruction,
   input  logic            d_is_instruction,
   input  logic [1:0]      i_prv,
   input  logic [1:0]      d_prv,
   output logic            i_ack,
   output logic            d_ack,
   output logic            i_err,
   output logic            d_err,
   output logic [PLEN-1:0] i_adro,
   output logic [PLEN-1:0] d_adro,
   output logic [XLEN-1:0] i_do,
   output logic [XLEN-1:0] d_do,
   output logic            biu_stb,
   input  logic            biu_stb_ack,
   output logic [PLEN-1:0] biu_adri,
   output logic [2:0]      biu_size,
   output logic [2:0]      biu_type,
   output logic            biu_lock,
   output logic            biu_we,
   output logic            biu_is_cacheable,
   output logic            biu_is_instruction,
   output logic [XLEN-1:0] biu_di,
   output logic [1:0]      biu_prv,
   input  logic [PLEN-1:0] biu_adro,
   input  logic [XLEN-1:0] biu_do,
   input  logic            biu_ack,
   input  logic            biu_err
);
   localparam int CW = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;

   state_t          state, state_nxt;
   logic            owner, owner_nxt;            // 1 = data port
   logic            last_owner, last_owner_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [3:0]      qcnt, qcnt_nxt;

   logic own_stb, oth_stb, own_lock, in_gnt, q_full, yield, accept, done, sel_d;

   assign own_stb  = owner ? d_stb  : i_stb;
   assign oth_stb  = owner ? i_stb  : d_stb;
   assign own_lock = owner ? d_lock : i_lock;
   assign in_gnt   = (state == GNT_I) || (state == GNT_D);
   assign q_full   = (qcnt == 4'(QUANTUM));
   // Stop issuing the moment the quantum is spent so the grant gets exactly QUANTUM accepts.
   assign yield    = !own_lock && oth_stb && q_full;
   assign accept   = biu_stb && biu_stb_ack;
   // A completion with nothing outstanding is a protocol error and is dropped.
   assign done     = (biu_ack || biu_err) && (cnt != '0);
   assign cnt_nxt  = cnt + CW'(accept) - CW'(done);
   assign sel_d    = (state == IDLE) ? 1'b1 : owner;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b0;
         cnt        <= '0;
         qcnt       <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         cnt        <= cnt_nxt;
         qcnt       <= qcnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      case (state)
         IDLE: begin
            if (d_stb && (!i_stb || !last_owner)) begin
               state_nxt = GNT_D;
               owner_nxt = 1'b1;
            end else if (i_stb) begin
               state_nxt = GNT_I;
               owner_nxt = 1'b0;
            end
         end
         GNT_I, GNT_D: begin
            if (!own_lock) begin
               if (oth_stb && (!own_stb || q_full))
                  state_nxt = DRAIN;
               else if (!own_stb && !oth_stb && (cnt == '0))
                  state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (cnt_nxt == '0) begin
               last_owner_nxt = owner;
               if (oth_stb) begin
                  owner_nxt = !owner;
                  state_nxt = owner ? GNT_I : GNT_D;
               end else if (own_stb) begin
                  state_nxt = owner ? GNT_D : GNT_I;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      qcnt_nxt = qcnt;
      if ((state == IDLE || state == DRAIN) && state_nxt != state)
         qcnt_nxt = '0;
      else if (accept && !own_lock && !q_full)
         qcnt_nxt = qcnt + 4'd1;
   end

   always_comb begin
      biu_stb            = in_gnt && own_stb && (cnt < CW'(MAX_OUT)) && !yield;
      i_stb_ack          = accept && !owner;
      d_stb_ack          = accept && owner;
      i_ack              = (state != IDLE) && (cnt != '0) && !owner && biu_ack;
      d_ack              = (state != IDLE) && (cnt != '0) && owner  && biu_ack;
      i_err              = (state != IDLE) && (cnt != '0) && !owner && biu_err;
      d_err              = (state != IDLE) && (cnt != '0) && owner  && biu_err;
      biu_adri           = sel_d ? d_adri           : i_adri;
      biu_size           = sel_d ? d_size           : i_size;
      biu_type           = sel_d ? d_type           : i_type;
      biu_lock           = sel_d ? d_lock           : i_lock;
      biu_we             = sel_d ? d_we             : i_we;
      biu_di             = sel_d ? d_di             : i_di;
      biu_is_cacheable   = sel_d ? d_is_cacheable   : i_is_cacheable;
      biu_is_instruction = sel_d ? d_is_instruction : i_is_instruction;
      biu_prv            = sel_d ? d_prv            : i_prv;
   end

   assign i_adro = biu_adro;
   assign d_adro = biu_adro;
   assign i_do   = biu_do;
   assign d_do   = biu_do;

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Directed bench for riscv_biu_arbiter: BIU responder with programmable ack latency plus hand-computed checks.
module tb_riscv_biu_arbiter;
   localparam int XLEN = 64, PLEN = 64, MAX_OUT = 2, QUANTUM = 4;
   localparam logic [PLEN-1:0] I_ADR = 64'h1000;
   localparam logic [PLEN-1:0] D_ADR = 64'h2000;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic i_stb, d_stb, i_stb_ack, d_stb_ack, i_lock, d_lock, i_we, d_we;
   logic [PLEN-1:0] i_adri, d_adri, i_adro, d_adro, biu_adri, biu_adro;
   logic [2:0] i_size, d_size, i_type, d_type, biu_size, biu_type;
   logic [XLEN-1:0] i_di, d_di, i_do, d_do, biu_di, biu_do;
   logic i_is_cacheable, d_is_cacheable, i_is_instruction, d_is_instruction;
   logic [1:0] i_prv, d_prv, biu_prv;
   logic i_ack, d_ack, i_err, d_err;
   logic biu_stb, biu_stb_ack, biu_lock, biu_we, biu_is_cacheable, biu_is_instruction;
   logic biu_ack, biu_err;

   logic manual = 1'b0, man_ack = 1'b0, resp_ack = 1'b0, resp_err = 1'b0;
   int lat = 1, err_idx = -1, resp_n = 0;
   int total = 0, bad = 0;
   int acc_i = 0, acc_d = 0, n_iack = 0, n_dack = 0, n_ierr = 0, n_derr = 0;
   int outst = 0, viol = 0, nruns = 0;
   bit run_own [0:31];
   int run_len [0:31];
   int b_ai, b_ad, b_ia, b_da, b_ie, b_de;

   assign biu_ack = manual ? man_ack : resp_ack;
   assign biu_err = manual ? 1'b0    : resp_err;

   riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN), .MAX_OUT(MAX_OUT), .QUANTUM(QUANTUM)) dut (
      .clk(clk), .rstn(rstn),
      .i_stb(i_stb), .d_stb(d_stb), .i_stb_ack(i_stb_ack), .d_stb_ack(d_stb_ack),
      .i_adri(i_adri), .d_adri(d_adri), .i_size(i_size), .d_size(d_size),
      .i_type(i_type), .d_type(d_type), .i_lock(i_lock), .d_lock(d_lock),
      .i_we(i_we), .d_we(d_we), .i_di(i_di), .d_di(d_di),
      .i_is_cacheable(i_is_cacheable), .d_is_cacheable(d_is_cacheable),
      .i_is_instruction(i_is_instruction), .d_is_instruction(d_is_instruction),
      .i_prv(i_prv), .d_prv(d_prv), .i_ack(i_ack), .d_ack(d_ack),
      .i_err(i_err), .d_err(d_err), .i_adro(i_adro), .d_adro(d_adro),
      .i_do(i_do), .d_do(d_do), .biu_stb(biu_stb), .biu_stb_ack(biu_stb_ack),
      .biu_adri(biu_adri), .biu_size(biu_size), .biu_type(biu_type),
      .biu_lock(biu_lock), .biu_we(biu_we), .biu_is_cacheable(biu_is_cacheable),
      .biu_is_instruction(biu_is_instruction), .biu_di(biu_di), .biu_prv(biu_prv),
      .biu_adro(biu_adro), .biu_do(biu_do), .biu_ack(biu_ack), .biu_err(biu_err)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic snap();
      b_ai = acc_i; b_ad = acc_d; b_ia = n_iack; b_da = n_dack; b_ie = n_ierr; b_de = n_derr;
   endtask

   task automatic do_reset();
      i_stb = 1'b0; d_stb = 1'b0; i_lock = 1'b0; d_lock = 1'b0;
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   // BIU model: accepts every strobe, returns ack (or err for the tagged transfer) lat cycles later.
   initial begin
      logic [2:0] pa, pe;
      logic a, e;
      pa = '0; pe = '0;
      forever begin
         @(negedge clk);
         a = rstn && biu_stb && biu_stb_ack;
         e = a && (resp_n == err_idx);
         if (a) resp_n++;
         if (!rstn) begin pa = '0; pe = '0; end
         @(posedge clk);
         #1;
         pa = {pa[1:0], a};
         pe = {pe[1:0], e};
         resp_ack = pa[lat-1] && !pe[lat-1];
         resp_err = pa[lat-1] && pe[lat-1];
      end
   end

   // Event counters, protocol watch, and grant-run log.
   initial begin
      logic a, c;
      forever begin
         @(negedge clk);
         a = biu_stb && biu_stb_ack;
         c = biu_ack || biu_err;
         if (!rstn) begin
            outst = 0;
         end else begin
            if (biu_stb && outst >= MAX_OUT) viol++;
            if (c && outst == 0) viol++;
            if (i_stb_ack && d_stb_ack) viol++;
            outst = outst + int'(a) - int'(c && outst != 0);
            if (i_stb_ack) acc_i++;
            if (d_stb_ack) acc_d++;
            if (i_ack) n_iack++;
            if (d_ack) n_dack++;
            if (i_err) n_ierr++;
            if (d_err) n_derr++;
            if (a && nruns < 32) begin
               if (nruns == 0 || run_own[nruns-1] != d_stb_ack) begin
                  run_own[nruns] = d_stb_ack;
                  run_len[nruns] = 1;
                  nruns++;
               end else begin
                  run_len[nruns-1]++;
               end
            end
         end
      end
   end

   initial begin
      int n;
      bit found;
      i_adri = I_ADR; d_adri = D_ADR;
      i_size = 3'd2; d_size = 3'd3; i_type = 3'd0; d_type = 3'd0;
      i_we = 1'b0; d_we = 1'b1; i_di = 64'h11; d_di = 64'h22;
      i_is_cacheable = 1'b1; d_is_cacheable = 1'b0;
      i_is_instruction = 1'b1; d_is_instruction = 1'b0;
      i_prv = 2'd3; d_prv = 2'd0;
      biu_adro = 64'hABC0; biu_do = 64'h5555;
      biu_stb_ack = 1'b1;
      for (int k = 0; k < 32; k++) begin run_own[k] = 1'b0; run_len[k] = 0; end

      // Reset state and single-requester fetch stream.
      do_reset();
      lat = 1;
      snap();
      sample();
      chk("rst_biu_stb", biu_stb, 0);
      chk("rst_i_stb_ack", i_stb_ack, 0);
      chk("rst_d_stb_ack", d_stb_ack, 0);
      chk("rst_i_ack", i_ack, 0);
      chk("rst_d_err", d_err, 0);
      chk("rst_mux_d", biu_adri, D_ADR);
      step(); i_stb = 1'b1;
      sample();
      chk("t1_idle_stb", biu_stb, 0);
      step(); sample();
      chk("t1_gnt_stb", biu_stb, 1);
      chk("t1_i_stb_ack", i_stb_ack, 1);
      chk("t1_d_stb_ack", d_stb_ack, 0);
      chk("t1_mux_adr", biu_adri, I_ADR);
      chk("t1_mux_instr", biu_is_instruction, 1);
      step(); step(); step(); i_stb = 1'b0;
      repeat (3) step();
      chk("t1_accepts", acc_i - b_ai, 3);
      chk("t1_i_acks", n_iack - b_ia, 3);
      chk("t1_d_acks", n_dack - b_da, 0);
      chk("t1_adro_bcast", i_adro, 64'hABC0);

      // Tie from IDLE after reset: D first, then I once D drops and drains.
      do_reset();
      snap();
      i_stb = 1'b1; d_stb = 1'b1;
      step(); sample();
      chk("t2_d_first", d_stb_ack, 1);
      chk("t2_i_wait", i_stb_ack, 0);
      chk("t2_mux_d", biu_adri, D_ADR);
      step(); step(); d_stb = 1'b0;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         step(); n++; sample();
         if (i_stb_ack) break;
      end
      chk("t2_i_grant_lat", n, 2);
      chk("t2_d_accepts", acc_d - b_ad, 2);
      i_stb = 1'b0;
      repeat (3) step();

      // Quantum fairness with both requesters saturating.
      do_reset();
      lat = 2;
      nruns = 0;
      i_stb = 1'b1; d_stb = 1'b1;
      repeat (60) step();
      i_stb = 1'b0; d_stb = 1'b0;
      repeat (6) step();
      chk("t3_nruns_ge4", nruns >= 4, 1);
      for (int r = 0; r < 4; r++)
         chk($sformatf("t3_owner%0d", r), run_own[r], (r % 2 == 0) ? 1 : 0);
      for (int r = 0; r < 3; r++)
         chk($sformatf("t3_len%0d", r), run_len[r], QUANTUM);

      // Bus lock holds D past the quantum.
      do_reset();
      lat = 1;
      snap();
      d_lock = 1'b1; d_stb = 1'b1; i_stb = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (acc_d - b_ad >= 10) break;
      end
      d_stb = 1'b0; d_lock = 1'b0;
      chk("t4_d_accepts", acc_d - b_ad, 10);
      chk("t4_i_blocked", acc_i - b_ai, 0);
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         sample();
         if (i_stb_ack) begin found = 1'b1; break; end
         step();
      end
      chk("t4_i_granted", found, 1);
      i_stb = 1'b0;
      repeat (3) step();

      // Withheld acks: outstanding limit and simultaneous accept/ack.
      do_reset();
      manual = 1'b1; man_ack = 1'b0;
      snap();
      d_stb = 1'b1;
      step(); step(); step(); sample();
      chk("t5_full", biu_stb, 0);
      chk("t5_accepts", acc_d - b_ad, 2);
      step(); man_ack = 1'b1; sample();
      chk("t5_ack_full_stb", biu_stb, 0);
      chk("t5_ack_route", d_ack, 1);
      step(); sample();
      chk("t5_acc_and_ack", biu_stb, 1);
      step(); man_ack = 1'b0; sample();
      chk("t5_cnt_kept", biu_stb, 1);
      step(); sample();
      chk("t5_full_again", biu_stb, 0);
      step(); d_stb = 1'b0; man_ack = 1'b1;
      step(); step(); man_ack = 1'b0;
      step(); step();
      manual = 1'b0;

      // Error on the second of three data transfers.
      do_reset();
      lat = 1;
      err_idx = resp_n + 1;
      snap();
      d_stb = 1'b1;
      step(); step(); step(); sample();
      chk("t6_err_cycle", d_err, 1);
      chk("t6_no_ack_on_err", d_ack, 0);
      step(); d_stb = 1'b0;
      repeat (3) step();
      err_idx = -1;
      chk("t6_d_errs", n_derr - b_de, 1);
      chk("t6_d_acks", n_dack - b_da, 2);
      chk("t6_i_errs", n_ierr - b_ie, 0);
      i_stb = 1'b1;
      step(); sample();
      chk("t6_i_grant", i_stb_ack, 1);
      i_stb = 1'b0;
      repeat (3) step();

      // Asynchronous reset with two transfers in flight.
      do_reset();
      manual = 1'b1; man_ack = 1'b0;
      i_stb = 1'b1;
      step(); step(); step();
      man_ack = 1'b1;
      sample();
      chk("t7_pre_i_ack", i_ack, 1);
      chk("t7_pre_mux", biu_adri, I_ADR);
      #2 rstn = 1'b0;
      #1;
      chk("t7_rst_i_ack", i_ack, 0);
      chk("t7_rst_stb", biu_stb, 0);
      chk("t7_rst_stb_ack", i_stb_ack, 0);
      chk("t7_rst_idle_mux", biu_adri, D_ADR);
      man_ack = 1'b0; i_stb = 1'b0;
      step(); step();
      rstn = 1'b1;
      manual = 1'b0;
      step(); step();

      chk("proto_viol", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
